// File: rtl/bcd_calendar_clock_if.sv
// Key/set front-end and display-side signals of the BCD calendar clock.
// master = front-end (load/alarm/mode); slave = the clock core.
interface bcd_calendar_clock_if;
  logic       EN;
  logic       LOAD;
  logic [7:0] LD_SEC, LD_MIN, LD_HOUR, LD_DAY, LD_MON, LD_YEAR;
  logic       ALM_WR;
  logic [7:0] ALM_HOUR, ALM_MIN;
  logic       ALM_EN;
  logic       TWELVE_H;
  logic [7:0] SEC, MIN, HOUR, DAY, MON, YEAR;
  logic [7:0] HOUR_DISP;
  logic       PM;
  logic       SEC_TICK;
  logic       LOAD_ERR;
  logic       ALARM_HIT;

  modport master (
    output EN, LOAD, LD_SEC, LD_MIN, LD_HOUR, LD_DAY, LD_MON, LD_YEAR,
    output ALM_WR, ALM_HOUR, ALM_MIN, ALM_EN, TWELVE_H,
    input  SEC, MIN, HOUR, DAY, MON, YEAR, HOUR_DISP, PM,
    input  SEC_TICK, LOAD_ERR, ALARM_HIT
  );

  modport slave (
    input  EN, LOAD, LD_SEC, LD_MIN, LD_HOUR, LD_DAY, LD_MON, LD_YEAR,
    input  ALM_WR, ALM_HOUR, ALM_MIN, ALM_EN, TWELVE_H,
    output SEC, MIN, HOUR, DAY, MON, YEAR, HOUR_DISP, PM,
    output SEC_TICK, LOAD_ERR, ALARM_HIT
  );
endinterface

// File: rtl/bcd_calendar_clock.sv
// BCD calendar clock (2000-2099) with leap-aware rollover, validated load,
// 12/24h display hour and a minute-resolution alarm.
module bcd_calendar_clock #(
  parameter int TICK_DIV = 25000000,
  parameter bit LEAP_EN  = 1'b1
) (
  input logic                 CLK,
  input logic                 RST,
  bcd_calendar_clock_if.slave bus
);
  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

  // Leap test on the BCD year: divisible by 4 iff (even tens, units 0/4/8)
  // or (odd tens, units 2/6).
  function automatic logic leap_year(input logic [7:0] yr);
    if (!LEAP_EN) return 1'b0;
    if (yr[4]) return (yr[3:0] == 4'd2) || (yr[3:0] == 4'd6);
    return (yr[3:0] == 4'd0) || (yr[3:0] == 4'd4) || (yr[3:0] == 4'd8);
  endfunction

  function automatic logic [7:0] month_len(input logic [7:0] mon, input logic [7:0] yr);
    case (mon)
      8'h02:                      month_len = leap_year(yr) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
      default:                    month_len = 8'h31;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [PW-1:0] presc_reg;
  logic [7:0]    sec_reg, min_reg, hour_reg, day_reg, mon_reg, year_reg;
  logic [7:0]    alm_hour_reg, alm_min_reg;
  logic          sec_tick_reg, load_err_reg, alarm_hit_reg;
  logic [7:0]    sec_next, min_next, hour_next, day_next, mon_next, year_next;
  logic [7:0]    hour_12;

  logic          tc;
  logic          load_ok;
  logic [7:0]    ld_field [6];
  logic [5:0]    ld_digits_ok;

  assign tc = bus.EN && (presc_reg == PRESC_LAST);

  assign ld_field[0] = bus.LD_SEC;
  assign ld_field[1] = bus.LD_MIN;
  assign ld_field[2] = bus.LD_HOUR;
  assign ld_field[3] = bus.LD_DAY;
  assign ld_field[4] = bus.LD_MON;
  assign ld_field[5] = bus.LD_YEAR;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit_chk
      assign ld_digits_ok[gi] = (ld_field[gi][7:4] <= 4'd9) && (ld_field[gi][3:0] <= 4'd9);
    end
  endgenerate

  // Range compares on BCD bytes are numeric once every nibble is a digit.
  assign load_ok = (&ld_digits_ok)
                && (bus.LD_SEC  <= 8'h59) && (bus.LD_MIN <= 8'h59)
                && (bus.LD_HOUR <= 8'h23)
                && (bus.LD_MON  >= 8'h01) && (bus.LD_MON <= 8'h12)
                && (bus.LD_DAY  >= 8'h01)
                && (bus.LD_DAY  <= month_len(bus.LD_MON, bus.LD_YEAR));

  // Single-cycle ripple of the whole calendar by one second.
  always_comb begin
    sec_next  = (sec_reg == 8'h59) ? 8'h00 : bcd_inc(sec_reg);
    min_next  = min_reg;
    hour_next = hour_reg;
    day_next  = day_reg;
    mon_next  = mon_reg;
    year_next = year_reg;
    if (sec_reg == 8'h59) begin
      min_next = (min_reg == 8'h59) ? 8'h00 : bcd_inc(min_reg);
      if (min_reg == 8'h59) begin
        hour_next = (hour_reg == 8'h23) ? 8'h00 : bcd_inc(hour_reg);
        if (hour_reg == 8'h23) begin
          day_next = (day_reg == month_len(mon_reg, year_reg)) ? 8'h01 : bcd_inc(day_reg);
          if (day_reg == month_len(mon_reg, year_reg)) begin
            mon_next = (mon_reg == 8'h12) ? 8'h01 : bcd_inc(mon_reg);
            if (mon_reg == 8'h12) begin
              year_next = (year_reg == 8'h99) ? 8'h00 : bcd_inc(year_reg);
            end
          end
        end
      end
    end
  end

  always_comb begin
    hour_12 = hour_reg;
    case (hour_reg)
      8'h00: hour_12 = 8'h12;
      8'h13: hour_12 = 8'h01;
      8'h14: hour_12 = 8'h02;
      8'h15: hour_12 = 8'h03;
      8'h16: hour_12 = 8'h04;
      8'h17: hour_12 = 8'h05;
      8'h18: hour_12 = 8'h06;
      8'h19: hour_12 = 8'h07;
      8'h20: hour_12 = 8'h08;
      8'h21: hour_12 = 8'h09;
      8'h22: hour_12 = 8'h10;
      8'h23: hour_12 = 8'h11;
      default: hour_12 = hour_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_reg     <= '0;
      sec_reg       <= 8'h00;
      min_reg       <= 8'h00;
      hour_reg      <= 8'h00;
      day_reg       <= 8'h01;
      mon_reg       <= 8'h01;
      year_reg      <= 8'h00;
      alm_hour_reg  <= 8'h00;
      alm_min_reg   <= 8'h00;
      sec_tick_reg  <= 1'b0;
      load_err_reg  <= 1'b0;
      alarm_hit_reg <= 1'b0;
    end else begin
      sec_tick_reg  <= 1'b0;
      load_err_reg  <= 1'b0;
      alarm_hit_reg <= 1'b0;
      if (bus.ALM_WR) begin
        alm_hour_reg <= bus.ALM_HOUR;
        alm_min_reg  <= bus.ALM_MIN;
      end
      if (bus.LOAD && load_ok) begin
        // A valid load wins over a coincident tick and restarts the second.
        sec_reg   <= bus.LD_SEC;
        min_reg   <= bus.LD_MIN;
        hour_reg  <= bus.LD_HOUR;
        day_reg   <= bus.LD_DAY;
        mon_reg   <= bus.LD_MON;
        year_reg  <= bus.LD_YEAR;
        presc_reg <= '0;
      end else begin
        load_err_reg <= bus.LOAD;
        if (bus.EN) presc_reg <= tc ? '0 : presc_reg + PW'(1);
        if (tc) begin
          sec_reg       <= sec_next;
          min_reg       <= min_next;
          hour_reg      <= hour_next;
          day_reg       <= day_next;
          mon_reg       <= mon_next;
          year_reg      <= year_next;
          sec_tick_reg  <= 1'b1;
          alarm_hit_reg <= bus.ALM_EN && (sec_next == 8'h00)
                        && (min_next == alm_min_reg) && (hour_next == alm_hour_reg);
        end
      end
    end
  end

  assign bus.SEC       = sec_reg;
  assign bus.MIN       = min_reg;
  assign bus.HOUR      = hour_reg;
  assign bus.DAY       = day_reg;
  assign bus.MON       = mon_reg;
  assign bus.YEAR      = year_reg;
  assign bus.HOUR_DISP = bus.TWELVE_H ? hour_12 : hour_reg;
  assign bus.PM        = (hour_reg >= 8'h12);
  assign bus.SEC_TICK  = sec_tick_reg;
  assign bus.LOAD_ERR  = load_err_reg;
  assign bus.ALARM_HIT = alarm_hit_reg;
endmodule
